// File: rtl/regfile_dump.sv
// Sequential read-out of an inclusive (wrapping) register-file address range onto a valid/ready word stream.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum word after the last register word.
module regfile_dump #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  // state   | meaning
  // IDLE    | waiting for start
  // FETCH   | capture rdata for raddr into the stream registers
  // SEND    | word presented, waiting for handshake
  // CKSUM   | checksum word presented (checksum build only)
  // DONE    | one-cycle completion pulse
`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, SEND, CKSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, SEND, DONE} state_t;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW-1:0] last_q, last_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic          out_last_q, out_last_d;
  logic          hs;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DW-1:0] cksum_q, cksum_d;
`endif

  assign hs = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    cksum_d     = cksum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          raddr_d = first_addr;
          last_d  = last_addr;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          cksum_d = '0;
`endif
          state_d = FETCH;
        end
      end
      FETCH: begin
        out_data_d  = rdata;
        out_addr_d  = raddr_q;
        out_valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (raddr_q == last_q);
`endif
        state_d     = SEND;
      end
      SEND: begin
        if (hs) begin
          out_valid_d = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          cksum_d = cksum_q ^ out_data_q;
`endif
          if (raddr_q == last_q) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            // out_addr already holds last; re-present the stream with the final XOR
            out_valid_d = 1'b1;
            out_data_d  = cksum_q ^ out_data_q;
            out_last_d  = 1'b1;
            state_d     = CKSUM;
`else
            state_d     = DONE;
`endif
          end else begin
            raddr_d = raddr_q + AW'(1);
            state_d = FETCH;
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      CKSUM: begin
        if (hs) begin
          out_valid_d = 1'b0;
          state_d     = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      raddr_q     <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      cksum_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      cksum_q     <= cksum_d;
`endif
    end
  end

  assign raddr     = raddr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential read-out engine for the 32 x 32-bit register file. On a start pulse it walks a programmable, inclusive address range on one register-file read port. It captures each word and presents it on a valid/ready word stream together with its address. It is the reader counterpart to the register-file write path and feeds debug/trace logic, which may stall it at any time.

## Interface
- `DW`, 32, data width; must equal the register-file word width.
- `AW`, 5, register address width; register count is 2^AW.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a dump; ignored while `busy`.
- `first_addr`  in  AW  first register to read; sampled on accepted `start`.
- `last_addr`  in  AW  last register to read, inclusive; sampled on accepted `start`.
- `raddr`  out  AW  drives a register-file read-address input.
- `rdata`  in  DW  combinational read data returned for `raddr`.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DW  captured register value, or the checksum word.
- `out_addr`  out  AW  register address of `out_data`.
- `out_last`  out  1  final word of the dump.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the dump completes.

## Operation
- States: IDLE, FETCH, SEND, CKSUM (only when enabled), DONE.
- IDLE:
  - `start`=1 latches `first_addr` into `raddr` and `last_addr` into an internal register.
  - Moves to FETCH.
- FETCH:
  - Registers `rdata` into `out_data` and `raddr` into `out_addr`.
  - Sets `out_valid`=1 and `out_last` = (`raddr`==last).
  - Moves to SEND.
- SEND:
  - Holds all stream outputs until `out_valid`&&`out_ready`.
  - On that handshake, if `raddr`==last, moves to CKSUM or DONE and clears `out_valid`.
  - Otherwise sets `raddr` = `raddr`+1 mod 2^AW, clears `out_valid`, and moves to FETCH.
- DONE: `done`=1 for one cycle, then returns to IDLE.
- Range and wrap-around:
  - `last_addr` < `first_addr` wraps through 2^AW-1 to 0.
  - Word count is ((last-first) mod 2^AW)+1.
  - `first_addr`==`last_addr` gives exactly one word.
- Snapshot semantics: each word reflects the register contents at its FETCH edge. Writes to not-yet-fetched registers during a dump are visible in the stream. Writes to registers already fetched are not.
- `start` while `busy` has no effect. `start` in the same cycle as `done` is also ignored.
- `raddr` stays constant outside FETCH/SEND address increments, including while stalled.

## Timing
- Reset values: `raddr`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0, `busy`=0, `done`=0, state IDLE, checksum=0.
- Reset asserted mid-dump clears everything immediately, without waiting for `clk`. The dump is abandoned and no `done` is produced.
- `start` at edge N → `busy`=1 after edge N+1. First `out_valid`=1 after edge N+2.
- With `out_ready` held high, one word is issued every 2 cycles.
- After handshaking the last word at edge M, `done`=1 during the cycle after edge M+1, or after edge M+2 when the checksum word is enabled and accepted immediately.
- `busy` falls together with `done`.
- Stream rule: once `out_valid`=1, `out_data`/`out_addr`/`out_last` are stable until the handshake. `out_valid` never drops without a handshake, except on reset.

## Configuration
- Macro `REGFILE_DUMP_CHECKSUM_EN`.
- Defined:
  - A running XOR of all register words sent is kept; it is cleared on accepted `start`.
  - After the last register handshake, the CKSUM state presents one extra word with `out_data` = XOR, `out_addr` = last, `out_last`=1.
  - `out_last` is 0 on all register words.
- Undefined: no checksum logic or state; `out_last`=1 on the final register word.

## Test plan
- Full dump:
  - Stimulus: preload reg i = 0x01010101*i, then `start` with first=0, last=31, `out_ready`=1.
  - Response: 32 words, addr 0..31 with matching data, one word per 2 cycles, one `done` pulse, then `busy`=0.
- Wrap-around:
  - Stimulus: first=30, last=1.
  - Response: addresses 30, 31, 0, 1 in order, `out_last` on address 1 (checksum off).
- Backpressure:
  - Stimulus: `out_ready`=0 for 5 cycles while word 2 is valid.
  - Response: `out_valid`/`out_data`/`out_addr`/`raddr` stable; no dropped or duplicated word.
- Single register and start while busy:
  - Stimulus: first=last=7, then a second `start` while busy.
  - Response: exactly one word (addr 7); the second `start` is ignored.
- Reset mid-dump:
  - Stimulus: assert `rst` after 3 handshakes.
  - Response: all outputs 0 immediately and no `done`; a following `start` with first=0, last=1 produces 2 words.
- Checksum (macro defined):
  - Stimulus: regs 0..3 = 1, 2, 4, 8; first=0, last=3.
  - Response: 5 words, fifth has `out_data`=0xF, `out_addr`=3, `out_last`=1.
